// File: rtl/hazard_pkg.sv
// Shared encodings for the D-stage hazard unit: Tuse/Tnew width, the "operand unused"
// Tuse code and the mult/div operation classes.
package hazard_pkg;

  localparam int TW_DEFAULT = 2;

  localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_HILO = 2'b11
  } md_op_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and hazard response bundle between the decode stage (master) and
// the hazard unit (slave).
interface hazard_scoreboard_if #(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int TW     = 2
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  logic              d_we;
  logic [REG_AW-1:0] d_a3;
  logic [TW-1:0]     d_tnew;
  logic [1:0]        d_md_op;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic              md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew, d_md_op,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew, d_md_op,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/md_busy_counter.sv
// Mult/div busy timer: loaded when a mult or div leaves D, counts down to zero, and
// reports busy while nonzero.
module md_busy_counter #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load_mult,
  input  logic load_div,
  output logic busy
);
  localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load_div) begin
      count <= CW'(DIV_CYC);
    end else if (load_mult) begin
      count <= CW'(MULT_CYC);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit beside the D stage: a shift scoreboard of in-flight writers
// drives stall and nearest-producer forward selects; a busy timer guards HI/LO access.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int TW       = TW_DEFAULT,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic          clk,
  input logic          reset,
  hazard_scoreboard_if.slave hz
);
  localparam int SEL_W = $clog2(STAGES + 1);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] a3;
    logic [TW-1:0]     tnew;
  } entry_t;

  entry_t           sb      [STAGES];
  entry_t           sb_next [STAGES];
  logic             md_start_e;
  logic             md_busy;
  logic             stall;
  logic             md_stall;
  logic             data_stall_rs;
  logic             data_stall_rt;
  logic             issue_mult;
  logic             issue_div;
  logic [SEL_W-1:0] rs_sel;
  logic [SEL_W-1:0] rt_sel;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // A stalled D instruction is held in place, so E receives a bubble instead.
  assign sb_next[0] = stall ? '0 : entry_t'{we: hz.d_we, a3: hz.d_a3, tnew: hz.d_tnew};

  for (genvar k = 1; k < STAGES; k++) begin : g_shift
    assign sb_next[k] = entry_t'{we: sb[k-1].we, a3: sb[k-1].a3, tnew: sat_dec(sb[k-1].tnew)};
  end

  // NOTE: every scoreboard entry is reset, since a stale we bit would fake a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) sb[k] <= '0;
      md_start_e <= 1'b0;
    end else begin
      sb         <= sb_next;
      md_start_e <= issue_mult | issue_div;
    end
  end

  // Walk from oldest to youngest so the nearest matching producer wins.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    rs_sel        = '0;
    rt_sel        = '0;
    data_stall_rs = 1'b0;
    data_stall_rt = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (sb[k].we && (sb[k].a3 == hz.d_rs) && (hz.d_rs != '0)) begin
        rs_sel        = SEL_W'(k + 1);
        data_stall_rs = !(&hz.d_tuse_rs) && (sb[k].tnew > hz.d_tuse_rs);
      end
      if (sb[k].we && (sb[k].a3 == hz.d_rt) && (hz.d_rt != '0)) begin
        rt_sel        = SEL_W'(k + 1);
        data_stall_rt = !(&hz.d_tuse_rt) && (sb[k].tnew > hz.d_tuse_rt);
      end
    end
  end

  assign md_stall   = (hz.d_md_op != MD_NONE) && (md_busy || md_start_e);
  assign stall      = data_stall_rs | data_stall_rt | md_stall;
  assign issue_mult = !stall && (hz.d_md_op == MD_MULT);
  assign issue_div  = !stall && (hz.d_md_op == MD_DIV);

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset     (reset),
    .load_mult (issue_mult),
    .load_div  (issue_div),
    .busy      (md_busy)
  );

  assign hz.stall      = stall;
  assign hz.fwd_rs_sel = rs_sel;
  assign hz.fwd_rt_sel = rt_sel;
  assign hz.md_busy    = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each stimulus cycle queues its hand-computed
// response, and a negedge monitor pops and compares whatever the DUT presents.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [1:0] TN = TUSE_NONE;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  hazard_scoreboard_if #(.STAGES(3), .REG_AW(5), .TW(2)) hz_if ();

  hazard_scoreboard #(
    .STAGES(3), .REG_AW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // One D-stage cycle: drive the instruction and queue the response expected that cycle.
  task automatic step(input string name, input logic rst,
                      input logic [4:0] rs, input logic [1:0] trs,
                      input logic [4:0] rt, input logic [1:0] trt,
                      input logic we, input logic [4:0] a3, input logic [1:0] tnew,
                      input logic [1:0] md,
                      input logic es, input logic [1:0] ers, input logic [1:0] ert,
                      input logic eb);
    @(posedge clk);
    #1;
    reset           = rst;
    hz_if.d_rs      = rs;
    hz_if.d_tuse_rs = trs;
    hz_if.d_rt      = rt;
    hz_if.d_tuse_rt = trt;
    hz_if.d_we      = we;
    hz_if.d_a3      = a3;
    hz_if.d_tnew    = tnew;
    hz_if.d_md_op   = md;
    exp_q.push_back('{name: name, stall: es, rs_sel: ers, rt_sel: ert, busy: eb});
  endtask

  task automatic idle(input string name, input logic eb);
    step(name, 1'b0, 5'd0, TN, 5'd0, TN, 1'b0, 5'd0, 2'd0, MD_NONE, 1'b0, 2'd0, 2'd0, eb);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".stall"},   {1'b0, hz_if.stall},   {1'b0, e.stall});
      check({e.name, ".rs_sel"},  hz_if.fwd_rs_sel,      e.rs_sel);
      check({e.name, ".rt_sel"},  hz_if.fwd_rt_sel,      e.rt_sel);
      check({e.name, ".md_busy"}, {1'b0, hz_if.md_busy}, {1'b0, e.busy});
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    hz_if.d_rs      = '0;
    hz_if.d_rt      = '0;
    hz_if.d_tuse_rs = TN;
    hz_if.d_tuse_rt = TN;
    hz_if.d_we      = 1'b0;
    hz_if.d_a3      = '0;
    hz_if.d_tnew    = '0;
    hz_if.d_md_op   = MD_NONE;
    repeat (2) @(posedge clk);

    idle("reset_state", 1'b0);

    // lw $1 (tnew 2) -> addu $2,$1,$3: one stall cycle, then forward from entry 1
    step("lw1",      1'b0, 5'd2, 2'd1, 5'd0, TN,   1'b1, 5'd1, 2'd2, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("addu_stl", 1'b0, 5'd1, 2'd1, 5'd3, 2'd1, 1'b1, 5'd2, 2'd1, MD_NONE, 1'b1, 2'd1, 2'd0, 1'b0);
    step("addu_fwd", 1'b0, 5'd1, 2'd1, 5'd3, 2'd1, 1'b1, 5'd2, 2'd1, MD_NONE, 1'b0, 2'd2, 2'd0, 1'b0);

    // ori $4 (tnew 1) -> beq $4,$4 (tuse 0): one stall cycle, then both from entry 1
    step("ori4",     1'b0, 5'd0, 2'd1, 5'd0, TN,   1'b1, 5'd4, 2'd1, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("beq_stl",  1'b0, 5'd4, 2'd0, 5'd4, 2'd0, 1'b0, 5'd0, 2'd0, MD_NONE, 1'b1, 2'd1, 2'd1, 1'b0);
    step("beq_fwd",  1'b0, 5'd4, 2'd0, 5'd4, 2'd0, 1'b0, 5'd0, 2'd0, MD_NONE, 1'b0, 2'd2, 2'd2, 1'b0);

    // addu $5 -> sw $5,0($0) (tuse_rt 2): no stall, rt forwarded from E
    step("addu5",    1'b0, 5'd0, 2'd1, 5'd0, 2'd1, 1'b1, 5'd5, 2'd1, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("sw5",      1'b0, 5'd0, 2'd1, 5'd5, 2'd2, 1'b0, 5'd0, 2'd0, MD_NONE, 1'b0, 2'd0, 2'd1, 1'b0);

    // write to $0 with tnew 2, then jr $0: $0 never matches
    step("wr_r0",    1'b0, 5'd0, 2'd1, 5'd0, TN,   1'b1, 5'd0, 2'd2, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("jr_r0",    1'b0, 5'd0, 2'd0, 5'd0, TN,   1'b0, 5'd0, 2'd0, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);

    // Two writers of $7: the younger one decides both stall and forward source
    step("lw7",      1'b0, 5'd0, 2'd1, 5'd0, TN,   1'b1, 5'd7, 2'd2, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("addu7",    1'b0, 5'd0, 2'd1, 5'd0, TN,   1'b1, 5'd7, 2'd1, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b0);
    step("use7_stl", 1'b0, 5'd7, 2'd0, 5'd0, TN,   1'b0, 5'd0, 2'd0, MD_NONE, 1'b1, 2'd1, 2'd0, 1'b0);
    step("use7_fwd", 1'b0, 5'd7, 2'd0, 5'd0, TN,   1'b0, 5'd0, 2'd0, MD_NONE, 1'b0, 2'd2, 2'd0, 1'b0);

    // div then mfhi: mfhi held for exactly DIV_CYC cycles
    step("div",      1'b0, 5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, MD_DIV,  1'b0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      step($sformatf("mfhi_stl%0d", i), 1'b0, 5'd0, TN, 5'd0, TN, 1'b1, 5'd10, 2'd1, MD_HILO,
           1'b1, 2'd0, 2'd0, 1'b1);
    step("mfhi_go",  1'b0, 5'd0, TN,   5'd0, TN,   1'b1, 5'd10, 2'd1, MD_HILO, 1'b0, 2'd0, 2'd0, 1'b0);

    // Second div, a $11 writer in flight, reset while the timer reads 6
    step("div2",     1'b0, 5'd8, 2'd1, 5'd9, 2'd1, 1'b0, 5'd0, 2'd0, MD_DIV,  1'b0, 2'd0, 2'd0, 1'b0);
    idle("busy10", 1'b1);
    idle("busy9",  1'b1);
    step("wr11",     1'b0, 5'd0, TN,   5'd0, TN,   1'b1, 5'd11, 2'd2, MD_NONE, 1'b0, 2'd0, 2'd0, 1'b1);
    idle("busy7",  1'b1);
    step("rst_busy6", 1'b1, 5'd11, 2'd0, 5'd0, TN, 1'b1, 5'd10, 2'd1, MD_HILO, 1'b1, 2'd2, 2'd0, 1'b1);
    step("after_rst", 1'b0, 5'd11, 2'd0, 5'd0, TN, 1'b1, 5'd10, 2'd1, MD_HILO, 1'b0, 2'd0, 2'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never compared, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
